// File: rtl/intv_pll_pkg.sv
// Shared types and register map for the video PLL reconfiguration sequencer.
// C0/FRAC values select the NTSC or PAL pixel clock.
package intv_pll_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_MODE,
        S_W_N,
        S_W_M,
        S_W_C0,
        S_W_FRAC,
        S_W_START,
        S_SETTLE,
        S_LOCK_WAIT
    } state_e;

    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_START = 6'd2;
    localparam logic [5:0] ADDR_N     = 6'd3;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_C0    = 6'd5;
    localparam logic [5:0] ADDR_FRAC  = 6'd7;

    localparam logic [31:0] DATA_N     = 32'h0001_0000;
    localparam logic [31:0] DATA_M     = 32'h0000_0404;
    localparam logic [31:0] C0_NTSC    = 32'h0000_0505;
    localparam logic [31:0] C0_PAL     = 32'h0002_0504;
    localparam logic [31:0] FRAC_NTSC  = 32'h9745_BF27;
    localparam logic [31:0] FRAC_PAL   = 32'hA3D7_09E8;

    function automatic logic is_write(input state_e s);
        return s inside {S_W_MODE, S_W_N, S_W_M, S_W_C0, S_W_FRAC, S_W_START};
    endfunction

    function automatic logic [5:0] wr_addr(input state_e s);
        case (s)
            S_W_N:     return ADDR_N;
            S_W_M:     return ADDR_M;
            S_W_C0:    return ADDR_C0;
            S_W_FRAC:  return ADDR_FRAC;
            S_W_START: return ADDR_START;
            default:   return ADDR_MODE;
        endcase
    endfunction

    function automatic logic [31:0] wr_data(input state_e s, input logic pal);
        case (s)
            S_W_N:    return DATA_N;
            S_W_M:    return DATA_M;
            S_W_C0:   return pal ? C0_PAL : C0_NTSC;
            S_W_FRAC: return pal ? FRAC_PAL : FRAC_NTSC;
            default:  return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for slow asynchronous level inputs.
// No reset so the synchronized value survives a sequencer reset.
module sync2 (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        meta_q <= d;
        sync_q <= meta_q;
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reconfig_seq.sv
// Rewrites the video PLL for NTSC/PAL on standard change or after reset,
// holding the core in reset until the PLL relocks or times out.
module pll_reconfig_seq
    import intv_pll_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT  = 1_000_000,
    parameter int unsigned SETTLE_CYCLES = 64
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        pal,
    input  logic        pll_locked,
    input  logic        mgmt_waitrequest,
    output logic        mgmt_write,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        tv_reset,
    output logic        busy,
    output logic        done,
    output logic        lock_err
);

    localparam int unsigned ST_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int unsigned TO_W = $clog2(LOCK_TIMEOUT) + 1;

    logic pal_s;
    logic locked_s;

    sync2 u_sync_pal (.clk(clk_sys), .d(pal),        .q(pal_s));
    sync2 u_sync_lck (.clk(clk_sys), .d(pll_locked), .q(locked_s));

    state_e          state_q, state_d;
    logic            cfg_pal_q, cfg_pal_d;
    logic            pending_q, pending_d;
    logic [ST_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [TO_W-1:0] lock_cnt_q, lock_cnt_d;
    logic            tv_reset_q, tv_reset_d;
    logic            done_q, done_d;
    logic            lock_err_q, lock_err_d;
    logic            busy_q, busy_d;
    logic            mgmt_write_q, mgmt_write_d;
    logic [5:0]      mgmt_address_q, mgmt_address_d;
    logic [31:0]     mgmt_writedata_q, mgmt_writedata_d;

    always_comb begin
        state_d      = state_q;
        cfg_pal_d    = cfg_pal_q;
        pending_d    = pending_q;
        settle_cnt_d = settle_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        tv_reset_d   = tv_reset_q;
        lock_err_d   = lock_err_q;
        done_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pending_q || (pal_s != cfg_pal_q)) begin
                    state_d    = S_W_MODE;
                    cfg_pal_d  = pal_s;
                    pending_d  = 1'b0;
                    tv_reset_d = 1'b1;
                    lock_err_d = 1'b0;
                end
            end
            S_W_MODE: if (!mgmt_waitrequest) state_d = S_W_N;
            S_W_N:    if (!mgmt_waitrequest) state_d = S_W_M;
            S_W_M:    if (!mgmt_waitrequest) state_d = S_W_C0;
            S_W_C0:   if (!mgmt_waitrequest) state_d = S_W_FRAC;
            S_W_FRAC: if (!mgmt_waitrequest) state_d = S_W_START;
            S_W_START: begin
                if (!mgmt_waitrequest) begin
                    state_d      = S_SETTLE;
                    settle_cnt_d = '0;
                end
            end
            // Lock is ignored here: the old lock may still be asserted.
            S_SETTLE: begin
                if (settle_cnt_q == ST_W'(SETTLE_CYCLES - 1)) begin
                    state_d    = S_LOCK_WAIT;
                    lock_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + ST_W'(1);
                end
            end
            S_LOCK_WAIT: begin
                if (locked_s) begin
                    state_d    = S_IDLE;
                    tv_reset_d = 1'b0;
                    done_d     = 1'b1;
                end else if (lock_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
                    state_d    = S_IDLE;
                    tv_reset_d = 1'b0;
                    done_d     = 1'b1;
                    lock_err_d = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + TO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d           = (state_d != S_IDLE);
        mgmt_write_d     = is_write(state_d);
        mgmt_address_d   = wr_addr(state_d);
        mgmt_writedata_d = wr_data(state_d, cfg_pal_d);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            cfg_pal_q        <= 1'b0;
            pending_q        <= 1'b1;
            settle_cnt_q     <= '0;
            lock_cnt_q       <= '0;
            tv_reset_q       <= 1'b1;
            done_q           <= 1'b0;
            lock_err_q       <= 1'b0;
            busy_q           <= 1'b0;
            mgmt_write_q     <= 1'b0;
            mgmt_address_q   <= '0;
            mgmt_writedata_q <= '0;
        end else begin
            state_q          <= state_d;
            cfg_pal_q        <= cfg_pal_d;
            pending_q        <= pending_d;
            settle_cnt_q     <= settle_cnt_d;
            lock_cnt_q       <= lock_cnt_d;
            tv_reset_q       <= tv_reset_d;
            done_q           <= done_d;
            lock_err_q       <= lock_err_d;
            busy_q           <= busy_d;
            mgmt_write_q     <= mgmt_write_d;
            mgmt_address_q   <= mgmt_address_d;
            mgmt_writedata_q <= mgmt_writedata_d;
        end
    end

    assign mgmt_write     = mgmt_write_q;
    assign mgmt_address   = mgmt_address_q;
    assign mgmt_writedata = mgmt_writedata_q;
    assign tv_reset       = tv_reset_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign lock_err       = lock_err_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Scoreboard bench for pll_reconfig_seq: expected writes and completions
// are queued with the stimulus and retired by a bus monitor.
module tb_pll_reconfig_seq;

    localparam int S  = 8;
    localparam int TO = 100;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        pal = 1'b0;
    logic        pll_locked = 1'b0;
    logic        mgmt_waitrequest;
    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        tv_reset;
    logic        busy;
    logic        done;
    logic        lock_err;

    logic stall_en = 1'b0;
    logic block_c0 = 1'b0;
    int   st_cnt;
    int   cyc = 0;

    int n_total = 0;
    int n_bad   = 0;
    int n_start = 0;
    int n_done  = 0;
    int start_cyc = 0;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
        int          hold;
    } wr_t;

    typedef struct {
        logic err;
        int   delta;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];

    pll_reconfig_seq #(
        .LOCK_TIMEOUT (TO),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk_sys         (clk_sys),
        .reset_n         (reset_n),
        .pal             (pal),
        .pll_locked      (pll_locked),
        .mgmt_waitrequest(mgmt_waitrequest),
        .mgmt_write      (mgmt_write),
        .mgmt_address    (mgmt_address),
        .mgmt_writedata  (mgmt_writedata),
        .tv_reset        (tv_reset),
        .busy            (busy),
        .done            (done),
        .lock_err        (lock_err)
    );

    always #10 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Controller model: optional 3-cycle stall per write, or a hang on C0.
    assign mgmt_waitrequest = (stall_en && st_cnt < 3) ||
                              (block_c0 && mgmt_address == 6'd5);

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)                          st_cnt <= 0;
        else if (mgmt_write && mgmt_waitrequest) st_cnt <= st_cnt + 1;
        else                                   st_cnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic push_wr(input logic [5:0] a, input logic [31:0] d,
                           input int h);
        wq.push_back('{a: a, d: d, hold: h});
    endtask

    task automatic push_seq(input logic p, input int h);
        push_wr(6'd0, 32'h0000_0000, h);
        push_wr(6'd3, 32'h0001_0000, h);
        push_wr(6'd4, 32'h0000_0404, h);
        push_wr(6'd5, p ? 32'h0002_0504 : 32'h0000_0505, h);
        push_wr(6'd7, p ? 32'hA3D7_09E8 : 32'h9745_BF27, h);
        push_wr(6'd2, 32'h0000_0000, h);
    endtask

    task automatic lock_after_settle();
        int n0 = n_start;
        int t  = 0;
        while (n_start == n0 && t < 500) begin
            @(negedge clk_sys); #2;
            t++;
        end
        chk("start_seen", 32'(n_start != n0), 1);
        repeat (S + 10) @(negedge clk_sys);
        pll_locked = 1'b1;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (n_done < target && t < 1000) begin
            @(negedge clk_sys); #2;
            t++;
        end
        chk("done_seen", 32'(n_done >= target), 1);
    endtask

    task automatic wait_addr(input logic [5:0] a);
        int t = 0;
        while (!(mgmt_write && mgmt_address == a) && t < 200) begin
            @(negedge clk_sys); #2;
            t++;
        end
        chk("addr_seen", 32'(mgmt_write && mgmt_address == a), 1);
    endtask

    initial begin : mon
        int          hold;
        logic [5:0]  a0;
        logic [31:0] d0;
        logic        prev_done;
        wr_t         e;
        dn_t         de;
        hold = 0;
        a0 = '0;
        d0 = '0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                hold = 0;
                prev_done = 1'b0;
            end else begin
                if (mgmt_write) begin
                    chk("busy_in_wr", 32'(busy), 1);
                    if (hold == 0) begin
                        a0 = mgmt_address;
                        d0 = mgmt_writedata;
                    end else begin
                        chk("stall_addr", 32'(mgmt_address), 32'(a0));
                        chk("stall_data", mgmt_writedata, d0);
                    end
                    hold++;
                    if (!mgmt_waitrequest) begin
                        chk("wr_expected", 32'(wq.size() > 0), 1);
                        if (wq.size() > 0) begin
                            e = wq.pop_front();
                            chk("wr_addr", 32'(mgmt_address), 32'(e.a));
                            chk("wr_data", mgmt_writedata, e.d);
                            chk("wr_hold", hold, e.hold);
                        end
                        if (mgmt_address == 6'd2) begin
                            n_start++;
                            start_cyc = cyc;
                        end
                        hold = 0;
                    end
                end else begin
                    chk("idle_bus", 32'(mgmt_address != 0 ||
                                        mgmt_writedata != 0), 0);
                end
                if (done) begin
                    chk("done_width", 32'(prev_done), 0);
                    n_done++;
                    chk("done_expected", 32'(dq.size() > 0), 1);
                    if (dq.size() > 0) begin
                        de = dq.pop_front();
                        chk("done_lock_err", 32'(lock_err), 32'(de.err));
                        chk("done_tv_reset", 32'(tv_reset), 0);
                        chk("done_busy", 32'(busy), 0);
                        if (de.delta > 0)
                            chk("timeout_len", cyc - start_cyc, de.delta);
                    end
                end
                prev_done = done;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        repeat (5) @(negedge clk_sys);
        chk("rst_write", 32'(mgmt_write), 0);
        chk("rst_addr", 32'(mgmt_address), 0);
        chk("rst_data", mgmt_writedata, 0);
        chk("rst_tv_reset", 32'(tv_reset), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_lock_err", 32'(lock_err), 0);

        // Power-up sequence for NTSC, no stalls.
        push_seq(1'b0, 1);
        dq.push_back('{err: 1'b0, delta: 0});
        reset_n = 1'b1;
        lock_after_settle();
        wait_done(1);
        pll_locked = 1'b0;
        @(negedge clk_sys); #2;
        chk("tv_low_after_lock", 32'(tv_reset), 0);
        chk("idle_after_lock", 32'(busy), 0);

        // Switch to PAL with 3 stall cycles per write.
        stall_en = 1'b1;
        push_seq(1'b1, 4);
        dq.push_back('{err: 1'b0, delta: 0});
        pal = 1'b1;
        lock_after_settle();
        wait_done(2);
        pll_locked = 1'b0;
        stall_en = 1'b0;

        // Back to NTSC with no lock: timeout path.
        push_seq(1'b0, 1);
        dq.push_back('{err: 1'b1, delta: S + TO + 1});
        pal = 1'b0;
        wait_done(3);
        @(negedge clk_sys); #2;
        chk("lock_err_sticky", 32'(lock_err), 1);

        // PAL sequence with pal dropped during W_M, then NTSC restart.
        push_seq(1'b1, 1);
        push_seq(1'b0, 1);
        dq.push_back('{err: 1'b0, delta: 0});
        dq.push_back('{err: 1'b0, delta: 0});
        pal = 1'b1;
        wait_addr(6'd4);
        chk("lock_err_cleared", 32'(lock_err), 0);
        pal = 1'b0;
        lock_after_settle();
        wait_done(4);
        pll_locked = 1'b0;
        @(negedge clk_sys); #2;
        chk("restart_write", 32'(mgmt_write), 1);
        chk("restart_addr", 32'(mgmt_address), 0);
        chk("restart_tv_reset", 32'(tv_reset), 1);
        lock_after_settle();
        wait_done(5);
        pll_locked = 1'b0;

        // Reset while the C0 write is stalled.
        push_wr(6'd0, 32'h0000_0000, 1);
        push_wr(6'd3, 32'h0001_0000, 1);
        push_wr(6'd4, 32'h0000_0404, 1);
        block_c0 = 1'b1;
        pal = 1'b1;
        wait_addr(6'd5);
        repeat (2) @(negedge clk_sys);
        #3 reset_n = 1'b0;
        #1;
        chk("midrst_write", 32'(mgmt_write), 0);
        chk("midrst_addr", 32'(mgmt_address), 0);
        chk("midrst_tv_reset", 32'(tv_reset), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_wq", wq.size(), 0);
        block_c0 = 1'b0;
        repeat (3) @(negedge clk_sys);
        push_seq(1'b1, 1);
        dq.push_back('{err: 1'b0, delta: 0});
        reset_n = 1'b1;
        lock_after_settle();
        wait_done(6);
        pll_locked = 1'b0;

        repeat (5) @(negedge clk_sys);
        #2;
        chk("wq_empty", wq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        chk("done_count", n_done, 6);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_seq.md
PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

Interface
REQ-001 Parameter LOCK_TIMEOUT, default 1_000_000: clk_sys cycles to wait for pll_locked after the reconfig start before giving up.
REQ-002 Parameter SETTLE_CYCLES, default 64: clk_sys cycles to ignore pll_locked after the start write is accepted.
REQ-003 clk_sys  in  1  PLL management clock (50 MHz); the only clock.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 pal  in  1  video standard select (0 NTSC, 1 PAL); asynchronous to clk_sys.
REQ-006 pll_locked  in  1  lock indication from the reconfigured PLL; asynchronous.
REQ-007 mgmt_waitrequest  in  1  stall from the PLL reconfig controller.
REQ-008 mgmt_write  out  1  write strobe to the reconfig controller.
REQ-009 mgmt_address  out  6  reconfig register address.
REQ-010 mgmt_writedata  out  32  reconfig register data.
REQ-011 tv_reset  out  1  core reset request; high from sequence start until lock or timeout.
REQ-012 busy  out  1  high whenever the state is not IDLE.
REQ-013 done  out  1  one-cycle pulse when a sequence completes.
REQ-014 lock_err  out  1  sticky timeout flag; cleared at the start of the next sequence.

Function
REQ-015 pal and pll_locked shall each pass through a 2-flop synchronizer; pal_s denotes the synchronized pal.
REQ-016 States: IDLE, W_MODE, W_N, W_M, W_C0, W_FRAC, W_START, SETTLE, LOCK_WAIT.
REQ-017 Each W_* state shall drive these writes, in this order:
- W_MODE: addr 0, data 0
- W_N: addr 3, data 0x00010000
- W_M: addr 4, data 0x00000404
- W_C0: addr 5, data 0x00020504 (PAL) or 0x00000505 (NTSC)
- W_FRAC: addr 7, data 0xA3D709E8 (PAL) or 0x9745BF27 (NTSC)
- W_START: addr 2, data 0
REQ-018 In every W_* state mgmt_write shall be 1, with address and data held stable while mgmt_waitrequest=1.
REQ-019 A write shall be accepted in the cycle where mgmt_write=1 and mgmt_waitrequest=0; the FSM shall advance on the next edge, giving at most one accepted write per state.
REQ-020 The standard used for C0/FRAC shall be latched into cfg_pal on leaving IDLE; it shall not change within a sequence.
REQ-021 A sequence shall start (IDLE->W_MODE) when pal_s != cfg_pal, or when the first cycle after reset has pending set.
REQ-022 tv_reset shall rise on the IDLE->W_MODE transition.
REQ-023 After W_START is accepted, the FSM shall enter SETTLE and count SETTLE_CYCLES, then enter LOCK_WAIT.
REQ-024 LOCK_WAIT shall return to IDLE on synchronized pll_locked=1, or after LOCK_TIMEOUT cycles with lock_err set.
- In both cases tv_reset falls and done pulses on the same edge.
REQ-025 A pal_s change mid-sequence shall not abort the sequence; the mismatch remains and restarts it from IDLE one cycle after done.
- Multiple toggles ending at cfg_pal shall cause no restart.
REQ-026 Counters shall be sized $clog2 of their parameter, plus 1; the timeout count shall be inclusive (exactly LOCK_TIMEOUT cycles).
REQ-027 Outside W_* states: mgmt_write=0, mgmt_address=0, mgmt_writedata=0.

Reset
REQ-028 Asserting reset_n low shall force the following immediately, including mid-write (the outstanding write is dropped):
- state=IDLE
- mgmt_write=0, address/data=0
- tv_reset=1, busy=0, done=0, lock_err=0
- cfg_pal=0, pending=1
REQ-029 After release, one full sequence for the current pal_s shall run, so the PLL always matches the selection.

Structure
REQ-030 Package intv_pll_pkg shall hold:
- the state enum
- register address constants (MODE=0, START=2, N=3, M=4, C0=5, FRAC=7)
- the NTSC/PAL C0 and FRAC data constants
REQ-031 One sub-module, sync2 (2-flop synchronizer), instantiated twice; no other hierarchy.

Verification
REQ-032 Reset release with pal=0, waitrequest=0, and lock 10 cycles after SETTLE -> six writes (0/0, 3/0x00010000, 4/0x404, 5/0x505, 7/0x9745BF27, 2/0) on consecutive cycles; done pulses once; tv_reset low after lock.
REQ-033 pal 0->1 with waitrequest high for 3 cycles on each write -> each write held 4 cycles with stable address/data; C0=0x00020504, FRAC=0xA3D709E8.
REQ-034 pll_locked held 0 and LOCK_TIMEOUT=100 -> exactly 100 LOCK_WAIT cycles, then lock_err=1, done=1, tv_reset=0.
REQ-035 pal toggled 1->0 during W_M of a PAL sequence -> PAL sequence completes, then an NTSC sequence starts one cycle after done.
REQ-036 reset_n asserted during W_C0 with waitrequest=1 -> mgmt_write=0 and tv_reset=1 immediately; after release the full sequence restarts at W_MODE.
